// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port SRAM arbiter.
package sram_arb_pkg;

    typedef enum logic {
        IDLE,
        RMW_WR
    } arb_state_t;

    typedef enum logic {
        PORT_IMEM,
        PORT_DMEM
    } arb_port_t;

    localparam int unsigned BYTE_LANES = 4;
    localparam logic [BYTE_LANES-1:0] BE_FULL = 4'hF;

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Instruction port, data port and SRAM bank signals of the arbiter.
// The slave modport is the arbiter's view; master is the cores + SRAM side.
interface sram_port_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 14
) ();
    logic                  imem_req;
    logic [31:0]           imem_addr;
    logic                  imem_gnt;
    logic                  imem_rvalid;
    logic [31:0]           imem_rdata;

    logic                  dmem_req;
    logic                  dmem_we;
    logic [31:0]           dmem_addr;
    logic [31:0]           dmem_wdata;
    logic [3:0]            dmem_be;
    logic                  dmem_gnt;
    logic                  dmem_rvalid;
    logic [31:0]           dmem_rdata;

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic                  mem_we;
    logic                  mem_ce;
    logic [31:0]           mem_rdata;

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_gnt, dmem_rvalid, dmem_rdata,
        output mem_addr, mem_wdata, mem_we, mem_ce,
        input  mem_rdata
    );

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_gnt, dmem_rvalid, dmem_rdata,
        input  mem_addr, mem_wdata, mem_we, mem_ce,
        output mem_rdata
    );
endinterface

// File: rtl/sram_arb_rr2.sv
// Two-way round-robin picker: ties go to the port that did not win last.
module sram_arb_rr2
    import sram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    arb_port_t rr_last;

    // One-hot pick among active requests, only while enabled
    always_comb begin
        gnt = '0;
        if (en) begin
            if (req == 2'b11) begin
                gnt = (rr_last == PORT_DMEM) ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
        end
    end

    // Remember the most recent winner
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last <= PORT_DMEM;
        end else if (gnt[PORT_IMEM]) begin
            rr_last <= PORT_IMEM;
        end else if (gnt[PORT_DMEM]) begin
            rr_last <= PORT_DMEM;
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port SRAM bank between the instruction and data ports.
// Partial data writes become a read followed by a merged whole-word write.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned SRAM_BANK_ADDR_WIDTH = 14,
    parameter int unsigned SRAM_BANK_DATA_WIDTH = 32
) (
    input logic                i_clk,
    input logic                i_rst_n,
    sram_port_arbiter_if.slave bus
);

    if (SRAM_BANK_DATA_WIDTH != 32) begin : g_bad_width
        $error("sram_port_arbiter supports only a 32-bit bank word");
    end

    arb_state_t                      state;
    logic                            rdy;
    logic                            en;
    logic [1:0]                      req;
    logic [1:0]                      gnt;
    logic                            d_full;
    logic                            d_none;
    logic                            d_partial_wr;
    logic [SRAM_BANK_ADDR_WIDTH-1:0] rmw_addr;
    logic [31:0]                     rmw_wdata;
    logic [BYTE_LANES-1:0]           rmw_be;
    logic [31:0]                     merged;
    logic                            imem_rvalid_q;
    logic                            dmem_rvalid_q;
    logic                            dmem_rd_q;
    logic                            unused_addr_bits;

    assign unused_addr_bits = ^{bus.imem_addr[31:SRAM_BANK_ADDR_WIDTH+2], bus.imem_addr[1:0],
                                bus.dmem_addr[31:SRAM_BANK_ADDR_WIDTH+2], bus.dmem_addr[1:0]};

    assign en  = rdy && (state == IDLE);
    assign req = {bus.dmem_req, bus.imem_req};

    sram_arb_rr2 u_rr2 (
        .clk  (i_clk),
        .rst_n(i_rst_n),
        .req  (req),
        .en   (en),
        .gnt  (gnt)
    );

    assign d_full       = (bus.dmem_be == BE_FULL);
    assign d_none       = (bus.dmem_be == '0);
    assign d_partial_wr = bus.dmem_we && !d_full && !d_none;

    assign bus.imem_gnt    = gnt[PORT_IMEM];
    assign bus.dmem_gnt    = gnt[PORT_DMEM];
    assign bus.imem_rvalid = imem_rvalid_q;
    assign bus.dmem_rvalid = dmem_rvalid_q;
    // Read data passes straight from the bank in the response cycle
    assign bus.imem_rdata  = imem_rvalid_q ? bus.mem_rdata : '0;
    assign bus.dmem_rdata  = (dmem_rvalid_q && dmem_rd_q) ? bus.mem_rdata : '0;

    // Byte-lane merge of the old word with the registered partial write
    always_comb begin
        merged = '0;
        for (int unsigned k = 0; k < BYTE_LANES; k++) begin
            merged[8*k +: 8] = rmw_be[k] ? rmw_wdata[8*k +: 8] : bus.mem_rdata[8*k +: 8];
        end
    end

    // Bank access: RMW write-back, otherwise the winning request
    always_comb begin
        bus.mem_ce    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (state == RMW_WR) begin
            bus.mem_ce    = 1'b1;
            bus.mem_we    = 1'b1;
            bus.mem_addr  = rmw_addr;
            bus.mem_wdata = merged;
        end else if (gnt[PORT_IMEM]) begin
            bus.mem_ce   = 1'b1;
            bus.mem_addr = bus.imem_addr[SRAM_BANK_ADDR_WIDTH+1:2];
        end else if (gnt[PORT_DMEM]) begin
            bus.mem_addr = bus.dmem_addr[SRAM_BANK_ADDR_WIDTH+1:2];
            if (!bus.dmem_we) begin
                bus.mem_ce = 1'b1;
            end else if (d_full) begin
                bus.mem_ce    = 1'b1;
                bus.mem_we    = 1'b1;
                bus.mem_wdata = bus.dmem_wdata;
            end else if (!d_none) begin
                bus.mem_ce = 1'b1;
            end
        end
    end

    // FSM, ready flag, RMW capture and registered response flags
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= IDLE;
            rdy           <= 1'b0;
            rmw_addr      <= '0;
            rmw_wdata     <= '0;
            rmw_be        <= '0;
            imem_rvalid_q <= 1'b0;
            dmem_rvalid_q <= 1'b0;
            dmem_rd_q     <= 1'b0;
        end else begin
            rdy           <= 1'b1;
            imem_rvalid_q <= gnt[PORT_IMEM];
            // A partial write completes one cycle later, from RMW_WR
            dmem_rvalid_q <= (gnt[PORT_DMEM] && !d_partial_wr) || (state == RMW_WR);
            dmem_rd_q     <= gnt[PORT_DMEM] && !bus.dmem_we;
            case (state)
                IDLE: begin
                    if (gnt[PORT_DMEM] && d_partial_wr) begin
                        state     <= RMW_WR;
                        rmw_addr  <= bus.dmem_addr[SRAM_BANK_ADDR_WIDTH+1:2];
                        rmw_wdata <= bus.dmem_wdata;
                        rmw_be    <= bus.dmem_be;
                    end
                end
                RMW_WR:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed and random checks of sram_port_arbiter against a shadow-memory model.
`timescale 1ns/1ps
module tb_sram_port_arbiter;

    localparam int unsigned AW    = 14;
    localparam int unsigned DEPTH = 1 << AW;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sram_port_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

    sram_port_arbiter #(
        .SRAM_BANK_ADDR_WIDTH(AW),
        .SRAM_BANK_DATA_WIDTH(32)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    // Behavioural SRAM bank: registered read, whole-word write
    logic [31:0] sram    [DEPTH];
    logic [31:0] ref_mem [DEPTH];

    always @(posedge clk) begin
        if (bus.mem_ce) begin
            if (bus.mem_we) sram[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata      <= sram[bus.mem_addr];
        end
    end

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Reference model state
    typedef struct {
        int          due;
        logic [31:0] data;
    } rsp_t;

    int          cyc    = 0;
    bit          m_rdy  = 1'b0;
    int          m_last = 1;
    bit          m_block = 1'b0;
    int          m_blk_word = 0;
    logic [31:0] m_blk_data = '0;
    rsp_t        iq[$];
    rsp_t        dq[$];

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w, input logic [31:0] new_w,
                                                 input logic [3:0] be);
        logic [31:0] mask;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (old_w & ~mask) | (new_w & mask);
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = $urandom;
        a[15:2] = 14'($urandom_range(0, 15));
        return a;
    endfunction

    task automatic drive_idle();
        bus.imem_req   = 1'b0;
        bus.imem_addr  = '0;
        bus.dmem_req   = 1'b0;
        bus.dmem_we    = 1'b0;
        bus.dmem_addr  = '0;
        bus.dmem_wdata = '0;
        bus.dmem_be    = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_imem_gnt"}, bus.imem_gnt, 0);
        check({tag, "_dmem_gnt"}, bus.dmem_gnt, 0);
        check({tag, "_imem_rvalid"}, bus.imem_rvalid, 0);
        check({tag, "_dmem_rvalid"}, bus.dmem_rvalid, 0);
        check({tag, "_imem_rdata"}, bus.imem_rdata, 0);
        check({tag, "_dmem_rdata"}, bus.dmem_rdata, 0);
        check({tag, "_mem_ce"}, bus.mem_ce, 0);
        check({tag, "_mem_we"}, bus.mem_we, 0);
        check({tag, "_mem_addr"}, 32'(bus.mem_addr), 0);
        check({tag, "_mem_wdata"}, bus.mem_wdata, 0);
    endtask

    task automatic model_reset();
        iq.delete();
        dq.delete();
        m_rdy   = 1'b0;
        m_last  = 1;
        m_block = 1'b0;
    endtask

    // One clock cycle: inputs already driven; check at negedge, advance model, return at posedge+1
    task automatic step(output int win);
        logic        ireq, dreq, dwe, e_ce, e_we, exp_v;
        logic [3:0]  be;
        logic [31:0] wd, e_wd, exp_d;
        int          w_i, w_d, e_addr;
        bit          nb;
        @(negedge clk);
        ireq = bus.imem_req;
        dreq = bus.dmem_req;
        dwe  = bus.dmem_we;
        be   = bus.dmem_be;
        wd   = bus.dmem_wdata;
        w_i  = int'(bus.imem_addr[AW+1:2]);
        w_d  = int'(bus.dmem_addr[AW+1:2]);
        win  = -1;
        if (m_rdy && !m_block) begin
            if (ireq && dreq) win = (m_last == 1) ? 0 : 1;
            else if (ireq)    win = 0;
            else if (dreq)    win = 1;
        end
        check("imem_gnt", bus.imem_gnt, 32'(win == 0));
        check("dmem_gnt", bus.dmem_gnt, 32'(win == 1));

        exp_v = (iq.size() > 0) && (iq[0].due == cyc);
        exp_d = exp_v ? iq[0].data : '0;
        if (exp_v) void'(iq.pop_front());
        check("imem_rvalid", bus.imem_rvalid, 32'(exp_v));
        check("imem_rdata", bus.imem_rdata, exp_d);
        exp_v = (dq.size() > 0) && (dq[0].due == cyc);
        exp_d = exp_v ? dq[0].data : '0;
        if (exp_v) void'(dq.pop_front());
        check("dmem_rvalid", bus.dmem_rvalid, 32'(exp_v));
        check("dmem_rdata", bus.dmem_rdata, exp_d);

        e_ce = 1'b0; e_we = 1'b0; e_addr = 0; e_wd = '0;
        if (m_block) begin
            e_ce = 1'b1; e_we = 1'b1; e_addr = m_blk_word; e_wd = m_blk_data;
        end else if (win == 0) begin
            e_ce = 1'b1; e_addr = w_i;
        end else if (win == 1) begin
            e_addr = w_d;
            if (!dwe)            e_ce = 1'b1;
            else if (be == 4'hF) begin e_ce = 1'b1; e_we = 1'b1; e_wd = wd; end
            else if (be != 4'h0) e_ce = 1'b1;
        end
        check("mem_ce", bus.mem_ce, 32'(e_ce));
        check("mem_we", bus.mem_we, 32'(e_we));
        if (e_ce) check("mem_addr", 32'(bus.mem_addr), 32'(e_addr));
        if (e_we) check("mem_wdata", bus.mem_wdata, e_wd);

        nb = 1'b0;
        if (win == 0) begin
            iq.push_back('{cyc + 1, ref_mem[w_i]});
            m_last = 0;
        end
        if (win == 1) begin
            m_last = 1;
            if (!dwe) begin
                dq.push_back('{cyc + 1, ref_mem[w_d]});
            end else if (be == 4'hF) begin
                ref_mem[w_d] = wd;
                dq.push_back('{cyc + 1, 32'h0});
            end else if (be == 4'h0) begin
                dq.push_back('{cyc + 1, 32'h0});
            end else begin
                m_blk_data   = merge_bytes(ref_mem[w_d], wd, be);
                m_blk_word   = w_d;
                ref_mem[w_d] = m_blk_data;
                dq.push_back('{cyc + 2, 32'h0});
                nb = 1'b1;
            end
        end
        m_block = nb;
        m_rdy   = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        int          win;
        logic [31:0] old_w;

        for (int i = 0; i < int'(DEPTH); i++) begin
            sram[i]    = 32'hA500_0000 + 32'(i * 7);
            ref_mem[i] = sram[i];
        end
        sram[16] = 32'h1122_3344; ref_mem[16] = 32'h1122_3344;
        sram[1]  = 32'hAABB_CCDD; ref_mem[1]  = 32'hAABB_CCDD;

        // Reset with requests active: everything held at zero
        drive_idle();
        bus.imem_req = 1'b1;
        bus.dmem_req = 1'b1; bus.dmem_we = 1'b1; bus.dmem_be = 4'hF;
        bus.dmem_wdata = 32'hFFFF_FFFF;
        @(posedge clk); @(posedge clk); #1;
        check_all_zero("reset");

        // Both ports request every cycle; first cycle after release has no grant
        model_reset();
        bus.dmem_we = 1'b0; bus.dmem_be = '0;
        bus.imem_addr = 32'h0; bus.dmem_addr = 32'h4;
        rst_n = 1'b1;
        for (int i = 0; i < 7; i++) step(win);

        // Single instruction read
        drive_idle(); step(win);
        bus.imem_req = 1'b1; bus.imem_addr = 32'h40;
        step(win);
        drive_idle(); step(win);

        // Partial write with an instruction request arriving during write-back
        bus.dmem_req = 1'b1; bus.dmem_we = 1'b1; bus.dmem_addr = 32'h4;
        bus.dmem_wdata = 32'h1122_3344; bus.dmem_be = 4'b0101;
        step(win);
        drive_idle(); bus.imem_req = 1'b1; bus.imem_addr = 32'h40;
        step(win);
        step(win);
        drive_idle(); bus.dmem_req = 1'b1; bus.dmem_addr = 32'h4;
        step(win);
        drive_idle(); step(win);
        check("rmw_word", sram[1], 32'hAA22_CC44);

        // Full write, read-back, zero-enable write, read-back
        bus.dmem_req = 1'b1; bus.dmem_we = 1'b1; bus.dmem_addr = 32'h8;
        bus.dmem_wdata = 32'hDEAD_BEEF; bus.dmem_be = 4'hF;
        step(win);
        bus.dmem_we = 1'b0; bus.dmem_be = '0;
        step(win);
        bus.dmem_we = 1'b1; bus.dmem_wdata = 32'h1234_5678; bus.dmem_be = 4'h0;
        step(win);
        bus.dmem_we = 1'b0;
        step(win);
        drive_idle(); step(win);
        check("be0_word", sram[2], 32'hDEAD_BEEF);

        // Reset while the partial write is in its write-back cycle
        old_w = sram[3];
        bus.dmem_req = 1'b1; bus.dmem_we = 1'b1; bus.dmem_addr = 32'hC;
        bus.dmem_wdata = 32'h0000_FFFF; bus.dmem_be = 4'b0011;
        step(win);
        drive_idle();
        #1 rst_n = 1'b0;
        #1 check_all_zero("mid_rmw_reset");
        @(posedge clk); #1;
        check("abandoned_rmw_word", sram[3], old_w);
        ref_mem[3] = old_w;
        model_reset();
        rst_n = 1'b1;
        bus.imem_req = 1'b1; bus.imem_addr = 32'h40;
        bus.dmem_req = 1'b1; bus.dmem_addr = 32'hC;
        for (int i = 0; i < 4; i++) step(win);

        // Random traffic, requests held until the model grants them
        drive_idle();
        for (int c = 0; c < 400; c++) begin
            if (!bus.imem_req && $urandom_range(0, 3) != 0) begin
                bus.imem_req  = 1'b1;
                bus.imem_addr = rand_addr();
            end
            if (!bus.dmem_req && $urandom_range(0, 2) != 0) begin
                bus.dmem_req   = 1'b1;
                bus.dmem_we    = 1'($urandom_range(0, 1));
                bus.dmem_addr  = rand_addr();
                bus.dmem_wdata = $urandom;
                bus.dmem_be    = 4'($urandom_range(0, 15));
            end
            step(win);
            if (win == 0) bus.imem_req = 1'b0;
            if (win == 1) bus.dmem_req = 1'b0;
        end
        drive_idle();
        for (int i = 0; i < 3; i++) step(win);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
